// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader: scans a BRAM frame and streams it as valid/ready pixels,
// optionally replicated x2 or decimated /2, tolerating BRAM latency and backpressure.
module lcd_frame_reader #(
    parameter int PIX_W    = 16,
    parameter int ADDR_W   = 16,
    parameter int SRC_W    = 160,
    parameter int SRC_H    = 120,
    parameter int BRAM_LAT = 1,
    parameter int FIFO_D   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        scale_mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              bram_en_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    input  logic [PIX_W-1:0]  bram_data_i,
    output logic [PIX_W-1:0]  pix_data_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              pix_sof_o,
    output logic              pix_eol_o,
    output logic              pix_eof_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int PW = $clog2(FIFO_D);
    localparam int CW = PW + 1;
    localparam int XW = $clog2(2 * SRC_W);
    localparam int YW = $clog2(2 * SRC_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   row_base_q, addr_q;
    logic [XW-1:0]       x_q, ox_q;
    logic [YW-1:0]       row_q, oy_q;
    logic                pass_q, rep_q, en_q, done_q;
    logic [BRAM_LAT-1:0] pipe_q;
    logic [PIX_W-1:0]    mem_q [FIFO_D];
    logic [PW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       cnt_q;

    logic              idle, room, issue, row_end, pass_end, last_read, valid, fire, pop, ret, eol, eof;
    logic [1:0]        cur_mode;
    logic [ADDR_W-1:0] cur_rb, row_base_d;
    logic [XW-1:0]     cur_x, xstep, x_d, ow_last;
    logic [YW-1:0]     cur_row, row_d, oh_last;
    logic              cur_pass, pass_d;
    logic [CW-1:0]     cnt_d;

    // While idle the read cursor is taken straight from the inputs so the
    // first read goes out in the cycle right after start.
    assign idle      = state_q == IDLE;
    assign cur_mode  = idle ? (scale_mode_i == 2'd3 ? 2'd0 : scale_mode_i) : mode_q;
    assign cur_rb    = idle ? base_addr_i : row_base_q;
    assign cur_x     = idle ? '0 : x_q;
    assign cur_row   = idle ? '0 : row_q;
    assign cur_pass  = idle ? 1'b0 : pass_q;
    assign room      = int'(cnt_q) + $countones({pipe_q, en_q}) < FIFO_D;
    assign issue     = !abort_i && (idle ? start_i && !done_q : state_q == RUN && room);
    assign xstep     = cur_mode == 2'd2 ? XW'(2) : XW'(1);
    assign row_end   = cur_x == XW'(SRC_W) - xstep;
    assign pass_end  = cur_mode != 2'd1 || cur_pass;
    assign last_read = row_end && pass_end &&
                       cur_row == (cur_mode == 2'd2 ? YW'(SRC_H / 2 - 1) : YW'(SRC_H - 1));
    assign x_d        = row_end ? '0 : cur_x + xstep;
    assign pass_d     = row_end ? cur_mode == 2'd1 && !cur_pass : cur_pass;
    assign row_d      = row_end && pass_end ? cur_row + YW'(1) : cur_row;
    assign row_base_d = row_end && pass_end ?
                        cur_rb + (cur_mode == 2'd2 ? ADDR_W'(2 * SRC_W) : ADDR_W'(SRC_W)) : cur_rb;

    assign ow_last = mode_q == 2'd1 ? XW'(2 * SRC_W - 1) : mode_q == 2'd2 ? XW'(SRC_W / 2 - 1) : XW'(SRC_W - 1);
    assign oh_last = mode_q == 2'd1 ? YW'(2 * SRC_H - 1) : mode_q == 2'd2 ? YW'(SRC_H / 2 - 1) : YW'(SRC_H - 1);
    assign ret     = pipe_q[BRAM_LAT-1];
    assign valid   = cnt_q != '0;
    assign fire    = valid && pix_ready_i;
    assign pop     = fire && (mode_q != 2'd1 || rep_q);
    assign eol     = ox_q == ow_last;
    assign eof     = eol && oy_q == oh_last;
    assign cnt_d   = cnt_q + CW'(ret) - CW'(pop);

    assign bram_en_o   = en_q;
    assign bram_addr_o = addr_q;
    assign pix_valid_o = valid;
    assign pix_data_o  = valid ? mem_q[rd_q] : '0;
    assign pix_sof_o   = valid && ox_q == '0 && oy_q == '0;
    assign pix_eol_o   = valid && eol;
    assign pix_eof_o   = valid && eof;
    assign busy_o      = !idle;
    assign done_o      = done_q;

    always_ff @(posedge clk) begin
        if (ret) mem_q[wr_q] <= bram_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            x_q        <= '0;
            row_q      <= '0;
            pass_q     <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            pipe_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            rep_q      <= 1'b0;
        end else if (abort_i) begin
            // Clearing the return pipe discards every read still in flight.
            state_q <= IDLE;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            pipe_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            rep_q   <= 1'b0;
        end else begin
            en_q   <= issue;
            pipe_q <= BRAM_LAT'({pipe_q, en_q});
            done_q <= fire && eof;
            cnt_q  <= cnt_d;
            if (issue) begin
                addr_q     <= cur_rb + ADDR_W'(cur_x);
                mode_q     <= cur_mode;
                x_q        <= x_d;
                pass_q     <= pass_d;
                row_q      <= row_d;
                row_base_q <= row_base_d;
                state_q    <= last_read ? DRAIN : RUN;
            end
            if (fire && eof) state_q <= IDLE;
            if (ret) wr_q <= wr_q + PW'(1);
            if (pop) rd_q <= rd_q + PW'(1);
            if (fire) begin
                rep_q <= mode_q == 2'd1 && !rep_q;
                ox_q  <= eol ? '0 : ox_q + XW'(1);
                oy_q  <= eof ? '0 : eol ? oy_q + YW'(1) : oy_q;
            end
        end
    end
endmodule

// File: tb/tb_lcd_frame_reader.sv
// tb_lcd_frame_reader: random-backpressure frame bench checked against a
// per-frame expected pixel list built from output coordinates.
`timescale 1ns/1ps
module tb_lcd_frame_reader;
    localparam int PIX_W = 16, ADDR_W = 8, SRC_W = 8, SRC_H = 4, BRAM_LAT = 3, FIFO_D = 4;

    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0, pix_ready_i = 1'b0;
    logic [1:0]        scale_mode_i = '0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic              bram_en_o, pix_valid_o, pix_sof_o, pix_eol_o, pix_eof_o, busy_o, done_o;
    logic [ADDR_W-1:0] bram_addr_o;
    logic [PIX_W-1:0]  bram_data_i, pix_data_o;
    logic [30:0]       outs;
    logic [PIX_W-1:0]  bmem [256];
    logic [ADDR_W-1:0] ap [BRAM_LAT];
    logic [PIX_W+2:0]  exp_q [$];
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    lcd_frame_reader #(
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W), .SRC_H(SRC_H),
        .BRAM_LAT(BRAM_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .scale_mode_i(scale_mode_i), .base_addr_i(base_addr_i),
        .bram_en_o(bram_en_o), .bram_addr_o(bram_addr_o), .bram_data_i(bram_data_i),
        .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
        .pix_sof_o(pix_sof_o), .pix_eol_o(pix_eol_o), .pix_eof_o(pix_eof_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // Fixed-latency BRAM: data for an address appears BRAM_LAT cycles later.
    always @(posedge clk) begin
        ap[0] <= bram_addr_o;
        for (int i = 1; i < BRAM_LAT; i++) ap[i] <= ap[i-1];
    end
    assign bram_data_i = bmem[ap[BRAM_LAT-1]];
    assign outs = {bram_en_o, bram_addr_o, pix_data_o, pix_valid_o, pix_sof_o, pix_eol_o,
                   pix_eof_o, busy_o, done_o};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kill: 0 = run to completion, 1 = abort after 5 beats, 2 = reset after 5 beats
    task automatic run_frame(input int m, input int b, input int pct, input bit noise, input int kill);
        int ow, oh, mm, sx, sy, first, beats;
        bit fin, hold, stale;
        logic [PIX_W+2:0] got, e, held;
        mm = (m == 3) ? 0 : m;
        ow = mm == 1 ? 2 * SRC_W : mm == 2 ? SRC_W / 2 : SRC_W;
        oh = mm == 1 ? 2 * SRC_H : mm == 2 ? SRC_H / 2 : SRC_H;
        exp_q.delete();
        for (int y = 0; y < oh; y++)
            for (int x = 0; x < ow; x++) begin
                sx = mm == 1 ? x / 2 : mm == 2 ? 2 * x : x;
                sy = mm == 1 ? y / 2 : mm == 2 ? 2 * y : y;
                exp_q.push_back({bmem[(b + sy * SRC_W + sx) % 256], x == 0 && y == 0,
                                 x == ow - 1, x == ow - 1 && y == oh - 1});
            end
        @(posedge clk); #1;
        start_i = 1'b1; scale_mode_i = 2'(m); base_addr_i = 8'(b);
        @(posedge clk); #1;
        start_i = 1'b0; scale_mode_i = 2'($urandom); base_addr_i = 8'($urandom);
        check("issue", {busy_o, bram_en_o, bram_addr_o}, {2'b11, 8'(b)});
        first = -1; fin = 0; hold = 0; beats = 0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            if (kill != 0 && beats == 5) begin
                if (kill == 1) begin
                    abort_i = 1'b1; pix_ready_i = 1'b0;
                    @(posedge clk); #1;
                    abort_i = 1'b0;
                    check("abort", {busy_o, pix_valid_o, bram_en_o, done_o}, 4'b0);
                    stale = 0;
                    repeat (BRAM_LAT + 4) begin
                        @(negedge clk);
                        stale |= pix_valid_o | done_o;
                    end
                    check("stale", stale, 0);
                end else begin
                    rst_n = 1'b0; #1;
                    check("rst_mid", outs, 0);
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                end
                return;
            end
            pix_ready_i = $urandom_range(99) < pct;
            start_i = noise && busy_o && $urandom_range(3) == 0;
            if (noise) scale_mode_i = 2'($urandom);
            @(negedge clk);
            got = {pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o};
            if (hold) check("hold", {pix_valid_o, got}, {1'b1, held});
            hold = 0;
            if (pix_valid_o && first < 0) begin
                first = c;
                check("first_valid", c, 1 + BRAM_LAT);
            end
            if (pix_valid_o && pix_ready_i) begin
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("beat", got, e);
                    fin = e[0];
                end
                beats++;
            end else if (pix_valid_o) begin
                hold = 1; held = got;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            if (fin) begin
                check("done", {done_o, busy_o}, 2'b10);
                check("leftover", exp_q.size(), 0);
                start_i = 1'b1;
                @(posedge clk); #1;
                start_i = 1'b0;
                check("start_on_done", busy_o, 0);
            end else if (done_o) check("early_done", done_o, 0);
        end
        if (!fin) check("timeout", fin, 1);
    endtask

    initial begin
        foreach (bmem[a]) bmem[a] = {8'(a), 8'($urandom)};
        repeat (3) @(posedge clk);
        #1;
        check("reset", outs, 0);
        rst_n = 1'b1;
        run_frame(0, 0, 100, 0, 0);
        run_frame(1, 0, 100, 0, 0);
        run_frame(2, 16, 100, 0, 0);
        for (int m = 0; m < 4; m++) run_frame(m, $urandom_range(255), 50, 1, 0);
        run_frame(0, 0, 100, 0, 1);
        run_frame(0, 32, 100, 0, 0);
        run_frame(0, 0, 50, 0, 2);
        run_frame(0, 32, 50, 0, 0);
        @(posedge clk); #1;
        start_i = 1'b1; abort_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; abort_i = 1'b0;
        check("abort_wins", {busy_o, bram_en_o}, 2'b00);
        run_frame(1, 250, 70, 1, 0);
        run_frame(2, 250, 100, 0, 0);
        repeat (6) run_frame($urandom_range(3), $urandom_range(255), $urandom_range(30, 100), 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
